// File: rtl/primogen_multi_if.sv
// ---------------------------------------------------------------------------
// primogen_multi_if
// Command/result bundle for primogen_multi.
//   go         : command strobe, sampled only while ready=1
//   cmd        : 0=NEXT, 1=SEEK, 2=TEST, 3=reserved
//   arg        : operand for SEEK/TEST, sampled with go
//   ready      : engine idle and results valid
//   error      : last command failed
//   res        : current prime
//   is_prime   : TEST verdict
//   cache_full : prime cache holds its full number of entries
// master = command issuer, slave = primogen_multi.
// ---------------------------------------------------------------------------
interface primogen_multi_if #(
    parameter int WIDTH = 16
);
    logic             go;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] arg;
    logic             ready;
    logic             error;
    logic [WIDTH-1:0] res;
    logic             is_prime;
    logic             cache_full;

    modport master (
        output go, cmd, arg,
        input  ready, error, res, is_prime, cache_full
    );

    modport slave (
        input  go, cmd, arg,
        output ready, error, res, is_prime, cache_full
    );
endinterface

// File: rtl/primogen_multi.sv
// ---------------------------------------------------------------------------
// primogen_multi
// Prime engine serving NEXT / SEEK / TEST commands over one go/ready
// handshake. Consecutive odd primes 3,5,7,... found by NEXT are kept in a
// small synchronous-read ram and used as trial divisors; once the cache is
// exhausted, odd trial division continues from tail+2 (or 3 when empty).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : primogen_multi_if slave (go/cmd/arg in, ready/error/res/
//           is_prime/cache_full out, all outputs registered)
// Also holds the two helper blocks it uses: primogen_ram (synchronous-read
// cache store) and primogen_divrem (bit-serial remainder unit).
// ---------------------------------------------------------------------------

// Single-port ram, write-first not required: read data appears one clock
// after the address.
module primogen_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Storage write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end
endmodule

// Restoring divider returning the remainder. go is a one-cycle pulse; ready
// drops the following cycle and returns after W steps. A zero divisor sets
// err and leaves the unit idle.
module primogen_divrem #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         ready,
    output logic [W-1:0] rem,
    output logic         err
);
    localparam int CW = $clog2(W + 1);

    logic          busy_q, busy_d;
    logic          err_q,  err_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [W-1:0]  rem_q,  rem_d;
    logic [W-1:0]  sh_q,   sh_d;
    logic [W-1:0]  den_q,  den_d;
    logic [W:0]    trial_s;
    logic [W:0]    diff_s;

    // One restoring step per cycle: shift the next dividend bit into rem
    always_comb begin
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        den_d   = den_q;
        trial_s = {rem_q, sh_q[W-1]};
        diff_s  = trial_s - {1'b0, den_q};
        if (go) begin
            if (den == {W{1'b0}}) begin
                err_d  = 1'b1;
                busy_d = 1'b0;
            end else begin
                err_d  = 1'b0;
                busy_d = 1'b1;
                cnt_d  = CW'(W);
                rem_d  = {W{1'b0}};
                sh_d   = num;
                den_d  = den;
            end
        end else if (busy_q) begin
            if (trial_s >= {1'b0, den_q}) begin
                rem_d = diff_s[W-1:0];
            end else begin
                rem_d = trial_s[W-1:0];
            end
            sh_d  = {sh_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            rem_q  <= {W{1'b0}};
            sh_q   <= {W{1'b0}};
            den_q  <= {W{1'b0}};
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            sh_q   <= sh_d;
            den_q  <= den_d;
        end
    end

    assign ready = !busy_q;
    assign rem   = rem_q;
    assign err   = err_q;
endmodule

module primogen_multi #(
    parameter int WIDTH_LOG  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CACHE_EN   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    primogen_multi_if.slave    bus
);
    localparam int W = 1 << WIDTH_LOG;
    localparam logic [1:0] CMD_NEXT = 2'd0;
    localparam logic [1:0] CMD_SEEK = 2'd1;
    localparam logic [1:0] CMD_TEST = 2'd2;
    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [ADDR_WIDTH:0] DEPTH_N  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [3:0] {
        IDLE, ERROR, CANDIDATE, CACHE_DIV, CACHE_WAIT,
        SLOW_DIV, SLOW_WAIT, DONE_PRIME, DONE_COMPOSITE
    } state_t;

    // Full-precision square so d*d <= n never needs clamping
    function automatic logic [2*W-1:0] sq(input logic [W-1:0] x);
        logic [2*W-1:0] xe;
        xe = {{W{1'b0}}, x};
        return xe * xe;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [W-1:0]        n_q, n_d;          // candidate under test
    logic [W-1:0]        d_q, d_d;          // divisor handed to divrem
    logic [ADDR_WIDTH:0] idx_q, idx_d;      // cache read pointer
    logic [ADDR_WIDTH:0] naddrs_q, naddrs_d;
    logic [W-1:0]        tail_q, tail_d;    // largest cached prime
    logic [1:0]          ph_q, ph_d;        // phase inside the wait states
    logic                div_go_q, div_go_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;
    logic [W-1:0]        res_q, res_d;
    logic                is_prime_q, is_prime_d;
    logic                cache_full_q, cache_full_d;

    logic                ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [W-1:0]        ram_dout_s;
    logic                div_ready_s;
    logic [W-1:0]        div_rem_s;
    logic                div_err_s;
    logic [2*W-1:0]      n_ext_s;
    logic                tail_match_s;

    generate
        if (CACHE_EN != 0) begin : g_cache
            primogen_ram #(.AW(ADDR_WIDTH), .DW(W)) u_ram (
                .clk  (clk),
                .we   (ram_we_s),
                .addr (ram_addr_s),
                .din  (n_q),
                .dout (ram_dout_s)
            );
        end else begin : g_nocache
            assign ram_dout_s = {W{1'b0}};
        end
    endgenerate

    primogen_divrem #(.W(W)) u_divrem (
        .clk   (clk),
        .rst   (!rst_n),
        .go    (div_go_q),
        .num   (n_q),
        .den   (d_q),
        .ready (div_ready_s),
        .rem   (div_rem_s),
        .err   (div_err_s)
    );

    assign n_ext_s = {{W{1'b0}}, n_q};

    // A NEXT result may extend the cache only if it directly follows the tail
    always_comb begin
        if (naddrs_q == {(ADDR_WIDTH+1){1'b0}}) begin
            tail_match_s = (res_q == W'(2));
        end else begin
            tail_match_s = (res_q == tail_q);
        end
    end

    // Command sequencing and next-state / next-output computation
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        n_d          = n_q;
        d_d          = d_q;
        idx_d        = idx_q;
        naddrs_d     = naddrs_q;
        tail_d       = tail_q;
        ph_d         = ph_q;
        div_go_d     = 1'b0;
        ready_d      = ready_q;
        error_d      = error_q;
        res_d        = res_q;
        is_prime_d   = is_prime_q;
        cache_full_d = cache_full_q;
        ram_we_s     = 1'b0;
        ram_addr_s   = idx_q[ADDR_WIDTH-1:0];
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    cmd_d   = bus.cmd;
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    case (bus.cmd)
                        CMD_NEXT: begin
                            if (res_q == MAX_VAL) begin
                                state_d = ERROR;
                            end else begin
                                n_d     = res_q + W'(1);
                                state_d = CANDIDATE;
                            end
                        end
                        CMD_SEEK: begin
                            if (bus.arg < W'(2)) begin
                                n_d = W'(2);
                            end else begin
                                n_d = bus.arg;
                            end
                            state_d = CANDIDATE;
                        end
                        CMD_TEST: begin
                            n_d     = bus.arg;
                            state_d = CANDIDATE;
                        end
                        default: state_d = ERROR;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                ready_d = 1'b1;
                error_d = 1'b1;
                state_d = IDLE;
            end
            CANDIDATE: begin
                if ((cmd_q == CMD_TEST) && (n_q < W'(2))) begin
                    state_d = DONE_COMPOSITE;
                end else if (n_q == W'(2)) begin
                    state_d = DONE_PRIME;
                end else if ((cmd_q == CMD_TEST) && !n_q[0]) begin
                    state_d = DONE_COMPOSITE;
                end else begin
                    // Even NEXT/SEEK candidates (>2) round up; max even
                    // value + 1 still fits, so no wrap here
                    if (!n_q[0]) begin
                        n_d = n_q + W'(1);
                    end else begin
                        n_d = n_q;
                    end
                    if ((CACHE_EN != 0) && (naddrs_q != {(ADDR_WIDTH+1){1'b0}})) begin
                        idx_d   = {(ADDR_WIDTH+1){1'b0}};
                        state_d = CACHE_DIV;
                    end else begin
                        d_d     = W'(3);
                        state_d = SLOW_DIV;
                    end
                end
            end
            CACHE_DIV: begin
                // Address goes out now; ram data is valid in CACHE_WAIT
                if (idx_q == naddrs_q) begin
                    d_d     = tail_q + W'(2);
                    state_d = SLOW_DIV;
                end else begin
                    ph_d    = 2'd0;
                    state_d = CACHE_WAIT;
                end
            end
            CACHE_WAIT, SLOW_WAIT: begin
                case (ph_q)
                    2'd0: begin
                        if (sq(ram_dout_s) > n_ext_s) begin
                            state_d = DONE_PRIME;
                        end else begin
                            d_d      = ram_dout_s;
                            div_go_d = 1'b1;
                            ph_d     = 2'd1;
                        end
                    end
                    2'd1: begin
                        // divrem sees go this cycle; its ready is not yet valid
                        ph_d = 2'd2;
                    end
                    2'd2: begin
                        if (div_err_s) begin
                            state_d = ERROR;
                        end else if (div_ready_s) begin
                            if (div_rem_s == {W{1'b0}}) begin
                                state_d = DONE_COMPOSITE;
                            end else if (state_q == CACHE_WAIT) begin
                                idx_d   = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                                state_d = CACHE_DIV;
                            end else begin
                                d_d     = d_q + W'(2);
                                state_d = SLOW_DIV;
                            end
                        end else begin
                            ph_d = 2'd2;
                        end
                    end
                    default: ph_d = 2'd0;
                endcase
            end
            SLOW_DIV: begin
                if (sq(d_q) > n_ext_s) begin
                    state_d = DONE_PRIME;
                end else begin
                    div_go_d = 1'b1;
                    ph_d     = 2'd1;
                    state_d  = SLOW_WAIT;
                end
            end
            DONE_PRIME: begin
                ready_d    = 1'b1;
                is_prime_d = 1'b1;
                state_d    = IDLE;
                if (cmd_q != CMD_TEST) begin
                    res_d = n_q;
                end else begin
                    res_d = res_q;
                end
                ram_addr_s = naddrs_q[ADDR_WIDTH-1:0];
                if ((CACHE_EN != 0) && (cmd_q == CMD_NEXT) && tail_match_s &&
                    (naddrs_q < DEPTH_N)) begin
                    ram_we_s = 1'b1;
                    naddrs_d = naddrs_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    tail_d   = n_q;
                    if (naddrs_q == DEPTH_M1) begin
                        cache_full_d = 1'b1;
                    end else begin
                        cache_full_d = cache_full_q;
                    end
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            DONE_COMPOSITE: begin
                if (cmd_q == CMD_TEST) begin
                    ready_d    = 1'b1;
                    is_prime_d = 1'b0;
                    state_d    = IDLE;
                end else if (n_q > (MAX_VAL - W'(2))) begin
                    state_d = ERROR;
                end else begin
                    n_d     = n_q + W'(2);
                    state_d = CANDIDATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All engine state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= 2'd0;
            n_q          <= {W{1'b0}};
            d_q          <= {W{1'b0}};
            idx_q        <= {(ADDR_WIDTH+1){1'b0}};
            naddrs_q     <= {(ADDR_WIDTH+1){1'b0}};
            tail_q       <= {W{1'b0}};
            ph_q         <= 2'd0;
            div_go_q     <= 1'b0;
            ready_q      <= 1'b1;
            error_q      <= 1'b0;
            res_q        <= W'(2);
            is_prime_q   <= 1'b1;
            cache_full_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            n_q          <= n_d;
            d_q          <= d_d;
            idx_q        <= idx_d;
            naddrs_q     <= naddrs_d;
            tail_q       <= tail_d;
            ph_q         <= ph_d;
            div_go_q     <= div_go_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            res_q        <= res_d;
            is_prime_q   <= is_prime_d;
            cache_full_q <= cache_full_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.error      = error_q;
    assign bus.res        = res_q;
    assign bus.is_prime   = is_prime_q;
    assign bus.cache_full = cache_full_q;
endmodule
